// File: rtl/video_pkg.sv
// 640x480@60 timing constants and pixel-format selector shared by the framebuffer video slice.
package video_pkg;
    localparam int unsigned CNT_W     = 10;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int unsigned HS_START  = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END    = HS_START + H_SYNC;
    localparam int unsigned VS_START  = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END    = VS_START + V_SYNC;

    typedef enum logic {
        MODE_MONO   = 1'b0,
        MODE_RGB332 = 1'b1
    } mode_e;
endpackage

// File: rtl/fb_video_ctrl_if.sv
// CPU-side RAM access bus: requester drives req/we/addr/wdata, controller returns ack/rvalid/rdata.
interface fb_video_ctrl_if #(
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned RAM_WIDTH = 16
) ();
    logic                 cpu_req;
    logic                 cpu_we;
    logic [ADDR_W-1:0]    cpu_addr;
    logic [RAM_WIDTH-1:0] cpu_wdata;
    logic                 cpu_ack;
    logic                 cpu_rvalid;
    logic [RAM_WIDTH-1:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rvalid, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rvalid, cpu_rdata
    );
endinterface

// File: rtl/vga_timing.sv
// Half-rate pixel tick, 800x525 raster counters and the undelayed sync/blanking strobes.
module vga_timing
    import video_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic             tick,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             hs_raw,
    output logic             vs_raw,
    output logic             visible,
    output logic             vblank,
    output logic             frame_start
);
    logic x_last;
    logic y_last;

    always_comb begin
        x_last      = (x == CNT_W'(H_TOTAL - 1));
        y_last      = (y == CNT_W'(V_TOTAL - 1));
        hs_raw      = !((x >= CNT_W'(HS_START)) && (x < CNT_W'(HS_END)));
        vs_raw      = !((y >= CNT_W'(VS_START)) && (y < CNT_W'(VS_END)));
        visible     = (x < CNT_W'(H_VISIBLE)) && (y < CNT_W'(V_VISIBLE));
        vblank      = (y >= CNT_W'(V_VISIBLE));
        frame_start = tick && x_last && y_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick <= 1'b0;
            x    <= '0;
            y    <= '0;
        end else begin
            tick <= ~tick;
            if (tick) begin
                if (x_last) begin
                    x <= '0;
                    y <= y_last ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/fb_video_ctrl.sv
// Framebuffer scan-out: display fetch owns the RAM on tick=1, the CPU may borrow it on tick=0.
module fb_video_ctrl
    import video_pkg::*;
#(
    parameter int unsigned RAM_WIDTH               = 16,
    parameter int unsigned ADDR_W                  = 15,
    parameter int unsigned RAM_SCREEN_OFFSET       = 16384,
    parameter int unsigned BITS_PER_MEMORY_PIXEL_X = 5,
    parameter int unsigned BITS_PER_MEMORY_PIXEL_Y = 5,
    parameter logic [7:0]  FG_COLOR                = 8'hFF,
    parameter logic [7:0]  BG_COLOR                = 8'h00
) (
    input  logic                 CLK_50,
    input  logic                 RESET,
    input  logic                 mode,
    fb_video_ctrl_if.slave       cpu,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic                 ram_we,
    output logic [RAM_WIDTH-1:0] ram_wdata,
    input  logic [RAM_WIDTH-1:0] ram_rdata,
    output logic [2:0]           RED,
    output logic [2:0]           GREEN,
    output logic [1:0]           BLUE,
    output logic                 h_sync,
    output logic                 v_sync,
    output logic                 frame_start,
    output logic                 vblank
);
    localparam int unsigned MemCols = H_VISIBLE >> BITS_PER_MEMORY_PIXEL_X;
    localparam int unsigned PpwRgb  = RAM_WIDTH / 8;
    localparam int unsigned SelW    = $clog2(RAM_WIDTH);

    logic             tick;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             hs_raw;
    logic             vs_raw;
    logic             visible;

    mode_e            mode_q;
    logic [31:0]      lin;
    logic [31:0]      word_idx;
    logic [SelW-1:0]  bit_off;
    logic             grant;
    logic             rvalid_q;
    logic [7:0]       pix;

    // Fetch-stage metadata, carried across the RAM read latency.
    logic             s1_vis;
    logic             s1_hs;
    logic             s1_vs;
    logic [SelW-1:0]  s1_off;
    mode_e            s1_mode;

    vga_timing u_timing (
        .clk         (CLK_50),
        .rst         (RESET),
        .tick        (tick),
        .x           (x),
        .y           (y),
        .hs_raw      (hs_raw),
        .vs_raw      (vs_raw),
        .visible     (visible),
        .vblank      (vblank),
        .frame_start (frame_start)
    );

    always_comb begin
        lin = ((32'(y) >> BITS_PER_MEMORY_PIXEL_Y) * MemCols)
            + (32'(x) >> BITS_PER_MEMORY_PIXEL_X);
        if (mode_q == MODE_RGB332) begin
            word_idx = lin / PpwRgb;
            bit_off  = SelW'((lin % PpwRgb) * 8);
        end else begin
            word_idx = lin / RAM_WIDTH;
            bit_off  = SelW'(lin % RAM_WIDTH);
        end

        grant     = !RESET && !tick && cpu.cpu_req;
        ram_addr  = grant ? cpu.cpu_addr : ADDR_W'(RAM_SCREEN_OFFSET + word_idx);
        ram_we    = grant && cpu.cpu_we;
        ram_wdata = grant ? cpu.cpu_wdata : '0;

        if (!s1_vis) begin
            pix = 8'h00;
        end else if (s1_mode == MODE_RGB332) begin
            pix = 8'(ram_rdata >> s1_off);
        end else begin
            pix = ram_rdata[s1_off] ? FG_COLOR : BG_COLOR;
        end
    end

    assign cpu.cpu_ack    = grant;
    assign cpu.cpu_rvalid = rvalid_q;
    assign cpu.cpu_rdata  = ram_rdata;

    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            mode_q   <= MODE_MONO;
            rvalid_q <= 1'b0;
            s1_vis   <= 1'b0;
            s1_hs    <= 1'b1;
            s1_vs    <= 1'b1;
            s1_off   <= '0;
            s1_mode  <= MODE_MONO;
            RED      <= '0;
            GREEN    <= '0;
            BLUE     <= '0;
            h_sync   <= 1'b1;
            v_sync   <= 1'b1;
        end else begin
            rvalid_q <= grant && !cpu.cpu_we;
            if (frame_start) begin
                mode_q <= mode_e'(mode);
            end
            if (tick) begin
                s1_vis  <= visible;
                s1_hs   <= hs_raw;
                s1_vs   <= vs_raw;
                s1_off  <= bit_off;
                s1_mode <= mode_q;
            end else begin
                RED    <= pix[7:5];
                GREEN  <= pix[4:2];
                BLUE   <= pix[1:0];
                h_sync <= s1_hs;
                v_sync <= s1_vs;
            end
        end
    end
endmodule

// File: tb/tb_fb_video_ctrl.sv
// Directed bench: behavioural RAM, fetch-address/raster monitor and a CPU read scoreboard.
module tb_fb_video_ctrl;
    localparam int FRAME = 840000;

    logic        CLK_50 = 1'b0;
    logic        RESET;
    logic        mode;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [2:0]  RED;
    logic [2:0]  GREEN;
    logic [1:0]  BLUE;
    logic        h_sync;
    logic        v_sync;
    logic        frame_start;
    logic        vblank;

    fb_video_ctrl_if #(.ADDR_W(15), .RAM_WIDTH(16)) cpu_bus ();

    fb_video_ctrl dut (
        .CLK_50      (CLK_50),
        .RESET       (RESET),
        .mode        (mode),
        .cpu         (cpu_bus),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .RED         (RED),
        .GREEN       (GREEN),
        .BLUE        (BLUE),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .frame_start (frame_start),
        .vblank      (vblank)
    );

    always #5 CLK_50 = ~CLK_50;

    logic [15:0] mem [0:32767];
    always @(posedge CLK_50) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        mon_en = 1'b0;
    logic        exp_mode = 1'b0;
    int          fetch_bad = 0;
    int          we_bad = 0;
    int          vs_lo = 0;
    int          vs_lo_first = 0;
    int          fs_count = 0;
    int          fs_first = 0;
    int          fs_second = 0;
    logic [15:0] rd_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int fetch_exp(input int n, input logic m);
        int fp, x, y, l;
        fp = (n / 2) % (FRAME / 2);
        x  = fp % 800;
        y  = fp / 800;
        l  = (y >> 5) * 20 + (x >> 5);
        return 16384 + (m ? l / 2 : l / 16);
    endfunction

    function automatic int pix_cyc(input int f, input int x, input int y);
        return f * FRAME + 2 * (y * 800 + x) + 3;
    endfunction

    function automatic int cnt_cyc(input int f, input int x, input int y);
        return f * FRAME + 2 * (y * 800 + x);
    endfunction

    task automatic step();
        @(posedge CLK_50);
        #1;
        cyc++;
        if (mon_en) begin
            if ((cyc % 2) == 1 && ram_addr !== 15'(fetch_exp(cyc, exp_mode))) fetch_bad++;
            if (ram_we === 1'b1 && (cyc % 2) == 1) we_bad++;
            if (v_sync === 1'b0) vs_lo++;
            if (cpu_bus.cpu_rvalid === 1'b1) begin
                if (rd_q.size() == 0) chk("rvalid_unexpected", 32'(cpu_bus.cpu_rvalid), 0);
                else chk("rdata", 32'(cpu_bus.cpu_rdata), 32'(rd_q.pop_front()));
            end
            if (frame_start === 1'b1) begin
                if (fs_count == 0) begin
                    fs_first    = cyc;
                    vs_lo_first = vs_lo;
                end else if (fs_count == 1) begin
                    fs_second = cyc;
                end
                fs_count++;
                exp_mode = mode;
            end
        end
    endtask

    task automatic wait_until(input int n);
        if (cyc > n) chk("schedule", 32'(cyc), 32'(n));
        while (cyc < n) step();
    endtask

    // One reset edge, then release with any pending request withdrawn.
    task automatic do_reset();
        RESET  = 1'b1;
        mon_en = 1'b0;
        step();
        chk("rst_red", 32'(RED), 0);
        chk("rst_green", 32'(GREEN), 0);
        chk("rst_blue", 32'(BLUE), 0);
        chk("rst_hsync", 32'(h_sync), 1);
        chk("rst_vsync", 32'(v_sync), 1);
        chk("rst_ack", 32'(cpu_bus.cpu_ack), 0);
        chk("rst_rvalid", 32'(cpu_bus.cpu_rvalid), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_vblank", 32'(vblank), 0);
        cpu_bus.cpu_req = 1'b0;
        RESET    = 1'b0;
        cyc      = 0;
        mon_en   = 1'b1;
        exp_mode = 1'b0;
        vs_lo    = 0;
        fs_count = 0;
    endtask

    task automatic cpu_access(input logic we, input logic [14:0] addr, input logic [15:0] wd,
                              input logic [15:0] exp_rd);
        int lat;
        int exp_lat;
        lat     = 0;
        exp_lat = ((cyc % 2) == 0) ? 1 : 2;
        cpu_bus.cpu_req   = 1'b1;
        cpu_bus.cpu_we    = we;
        cpu_bus.cpu_addr  = addr;
        cpu_bus.cpu_wdata = wd;
        #1;
        while (cpu_bus.cpu_ack !== 1'b1 && lat < 4) begin
            step();
            lat++;
        end
        chk("ack_latency", 32'(lat + 1), 32'(exp_lat));
        if (!we) rd_q.push_back(exp_rd);
        step();
        cpu_bus.cpu_req = 1'b0;
        chk("rvalid_after_ack", 32'(cpu_bus.cpu_rvalid), 32'(!we));
        step();
        chk("rvalid_one_cycle", 32'(cpu_bus.cpu_rvalid), 0);
    endtask

    task automatic check_pix(input string tag, input int f, input int x, input int y,
                             input int r, input int g, input int b);
        wait_until(pix_cyc(f, x, y));
        chk({tag, "_red"}, 32'(RED), 32'(r));
        chk({tag, "_green"}, 32'(GREEN), 32'(g));
        chk({tag, "_blue"}, 32'(BLUE), 32'(b));
    endtask

    task automatic check_sync(input string tag, input int x, input int y, input int hs,
                              input int vs);
        wait_until(pix_cyc(0, x, y));
        chk({tag, "_hsync"}, 32'(h_sync), 32'(hs));
        chk({tag, "_vsync"}, 32'(v_sync), 32'(vs));
    endtask

    initial begin
        int hs_lo;
        RESET             = 1'b1;
        mode              = 1'b0;
        cpu_bus.cpu_req   = 1'b0;
        cpu_bus.cpu_we    = 1'b0;
        cpu_bus.cpu_addr  = '0;
        cpu_bus.cpu_wdata = '0;

        do_reset();
        cpu_access(1'b1, 15'd16384, 16'h0001, 16'h0000);
        cpu_access(1'b1, 15'd16387, 16'h0000, 16'h0000);
        cpu_access(1'b1, 15'd16414, 16'h001C, 16'h0000);
        do_reset();

        hs_lo = 0;
        repeat (1600) begin
            step();
            if (h_sync === 1'b0) hs_lo++;
        end
        chk("hsync_low_per_line", 32'(hs_lo), 192);

        check_pix("mono_x0_y1", 0, 0, 1, 7, 7, 3);
        check_pix("mono_x31_y1", 0, 31, 1, 7, 7, 3);
        check_pix("mono_x32_y1", 0, 32, 1, 0, 0, 0);
        check_pix("mono_x63_y1", 0, 63, 1, 0, 0, 0);
        check_pix("blank_x640_y1", 0, 640, 1, 0, 0, 0);
        check_sync("x655", 655, 1, 1, 1);
        check_sync("x656", 656, 1, 0, 1);
        check_sync("x751", 751, 1, 0, 1);
        check_sync("x752", 752, 1, 1, 1);
        check_pix("mono_x0_y31", 0, 0, 31, 7, 7, 3);
        check_pix("mono_x31_y31", 0, 31, 31, 7, 7, 3);
        check_pix("mono_x32_y31", 0, 32, 31, 0, 0, 0);

        wait_until(cnt_cyc(0, 100, 40));
        cpu_access(1'b1, 15'd16384, 16'hFFFF, 16'h0000);
        step();
        cpu_access(1'b0, 15'd16384, 16'h0000, 16'hFFFF);
        cpu_access(1'b0, 15'd16414, 16'h0000, 16'h001C);
        step();
        cpu_access(1'b1, 15'd16384, 16'hE01C, 16'h0000);
        cpu_access(1'b0, 15'd16384, 16'h0000, 16'hE01C);

        wait_until(cnt_cyc(0, 0, 100));
        mode = 1'b1;
        check_pix("latch_hold_a", 0, 0, 110, 0, 0, 0);

        wait_until(cnt_cyc(0, 799, 479));
        chk("vblank_y479", 32'(vblank), 0);
        wait_until(cnt_cyc(0, 0, 480));
        chk("vblank_y480", 32'(vblank), 1);
        check_sync("y489", 0, 489, 1, 1);
        check_sync("y490", 0, 490, 1, 0);
        check_sync("y491", 0, 491, 1, 0);
        check_sync("y492", 0, 492, 1, 1);

        check_pix("rgb_p0", 1, 0, 0, 0, 7, 0);
        check_pix("rgb_p0_x31", 1, 31, 0, 0, 7, 0);
        check_pix("rgb_p1", 1, 32, 0, 7, 0, 0);
        chk("frame_start_first", 32'(fs_first), 32'(FRAME - 1));
        chk("vsync_low_per_frame", 32'(vs_lo_first), 3200);

        wait_until(cnt_cyc(1, 0, 100));
        mode = 1'b0;
        check_pix("latch_hold_b", 1, 0, 110, 0, 7, 0);

        check_pix("latch_applied_c", 2, 0, 110, 0, 0, 0);
        chk("frame_start_period", 32'(fs_second - fs_first), 32'(FRAME));

        wait_until(cnt_cyc(2, 300, 200) + 1);
        cpu_bus.cpu_req  = 1'b1;
        cpu_bus.cpu_we   = 1'b0;
        cpu_bus.cpu_addr = 15'd16384;
        do_reset();
        wait_until(1);
        chk("restart_fetch_x0", 32'(ram_addr), 16384);
        wait_until(2 * 640 + 1);
        chk("restart_fetch_x640", 32'(ram_addr), 16385);
        repeat (4) step();

        chk("fetch_addr_errs", 32'(fetch_bad), 0);
        chk("ram_we_on_tick1", 32'(we_bad), 0);
        chk("read_queue_drained", 32'(rd_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fb_video_ctrl.md
FB_VIDEO_CTRL -- requirements
Module: fb_video_ctrl

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 16, RAM word width; power of two, >=8.
REQ-002 SHALL have parameter ADDR_W, default 15, RAM word-address width.
REQ-003 SHALL have parameter RAM_SCREEN_OFFSET, default 16384, word address of the first framebuffer word.
REQ-004 SHALL have parameters BITS_PER_MEMORY_PIXEL_X / _Y, default 5 / 5, log2 of screen pixels per memory pixel, horizontal / vertical.
REQ-005 SHALL have parameters FG_COLOR, default 8'hFF, and BG_COLOR, default 8'h00, RGB332 colours for mono mode.
REQ-006 SHALL have ports: CLK_50  in  1  sole clock; RESET  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: mode  in  1  0 = mono 1bpp, 1 = RGB332 8bpp; cpu_req  in  1; cpu_we  in  1; cpu_addr  in  ADDR_W; cpu_wdata  in  RAM_WIDTH.
REQ-008 SHALL have ports: cpu_ack  out  1; cpu_rvalid  out  1; cpu_rdata  out  RAM_WIDTH.
REQ-009 SHALL have ports: ram_addr  out  ADDR_W; ram_we  out  1; ram_wdata  out  RAM_WIDTH; ram_rdata  in  RAM_WIDTH, valid 1 cycle after ram_addr.
REQ-010 SHALL have ports: RED  out  3; GREEN  out  3; BLUE  out  2; h_sync  out  1; v_sync  out  1; frame_start  out  1; vblank  out  1.

Function
REQ-011 SHALL toggle internal tick every cycle; pixel counters x (0..799) and y (0..524) advance only in tick=1 cycles; x wraps to 0 and increments y; y wraps after 524.
REQ-012 SHALL, before the output delay, drive h_sync low for x in 656..751 and v_sync low for y in 490..491; visible region is x<640, y<480.
REQ-013 SHALL compute mx = x >> BITS_PER_MEMORY_PIXEL_X, my = y >> BITS_PER_MEMORY_PIXEL_Y, L = my*(640>>BITS_PER_MEMORY_PIXEL_X) + mx; PPW = RAM_WIDTH (mono) or RAM_WIDTH/8 (RGB).
REQ-014 SHALL drive, in tick=1 cycles, ram_addr = RAM_SCREEN_OFFSET + L/PPW, ram_we = 0; pixel slice L%PPW, LSB-first.
REQ-015 SHALL colour a visible pixel mono: bit=1 -> FG_COLOR, else BG_COLOR; RGB: byte {R[7:5],G[4:2],B[1:0]}; non-visible -> 0.
REQ-016 SHALL register RED/GREEN/BLUE, h_sync, v_sync at the end of the tick=0 cycle after the fetch, i.e. all outputs lag counters by exactly one pixel period (2 CLK_50 cycles), mutually aligned.
REQ-017 SHALL grant the RAM port to the CPU only in tick=0 cycles: when cpu_req=1, drive ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata, and cpu_ack=1 that same cycle.
REQ-018 SHALL never delay or skip a display fetch for a CPU access; cpu_ack latency from cpu_req rising is 1 or 2 cycles.
REQ-019 SHALL, for a granted read, assert cpu_rvalid for one cycle the cycle after cpu_ack with cpu_rdata = ram_rdata; writes produce no cpu_rvalid.
REQ-020 SHALL require the requester to hold cpu_req and cpu_* until cpu_ack; cpu_req held high after ack issues a new access at the next tick=0 cycle.
REQ-021 SHALL sample mode only in the cycle counters wrap to (0,0); mid-frame mode changes take effect next frame.
REQ-022 SHALL pulse frame_start for one cycle when counters wrap to (0,0); vblank = (y>=480), undelayed.

Reset
REQ-023 SHALL on RESET set tick=0, x=y=0, latched mode=0, RED/GREEN/BLUE=0, h_sync=v_sync=1, cpu_ack=cpu_rvalid=ram_we=frame_start=vblank=0.
REQ-024 SHALL abort a pending CPU request on RESET mid-operation without ack; a read acked in the reset cycle produces no cpu_rvalid.

Structure
REQ-025 SHALL place the 640x480 timing constants (visible, front porch, sync, back porch, totals) and the mode enum (MODE_MONO, MODE_RGB332) in package video_pkg.
REQ-026 SHALL factor tick, counters, raw syncs, visible, vblank and frame_start into sub-module vga_timing; fetch, arbitration and colour pipeline stay in fb_video_ctrl.

Verification
REQ-027 SHALL check free-run after reset: h_sync low 192 cycles per 1600; v_sync low 2 lines; frame_start every 840000 cycles.
REQ-028 SHALL check mono, RAM[16384]=16'h0001: x 0..31, y 0..31 -> RED=7, GREEN=7, BLUE=3; x 32..63 -> all 0.
REQ-029 SHALL check RGB332, RAM[16384]=16'hE01C: pixel 0 -> GREEN=7, others 0; pixel 1 -> RED=7, others 0.
REQ-030 SHALL check write cpu_addr=16384, cpu_wdata=16'hFFFF during active video: ack in <=2 cycles, ram_we only in a tick=0 cycle, display fetch addresses unchanged.
REQ-031 SHALL check read: cpu_rvalid exactly 1 cycle after cpu_ack with written data; mode flip at y=100 changes output only after next frame_start.
REQ-032 SHALL check RESET at x=300, y=200 with cpu_req pending: next cycle all outputs at reset values, no ack, counters restart at (0,0).
